// File: rtl/sequenciador_ula_xyz.sv
// ULA sequencer: executes ROM control words on X/Y/Z through an adder, enforcing step order.
// Optional SUBTRAI word (code 0101) is compiled in when the macro ULA_SUB_EN is defined.
module sequenciador_ula_xyz #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             valido,
   input  logic [3:0]       saida,
   input  logic [WIDTH-1:0] valor,
   output logic [WIDTH-1:0] reg_x,
   output logic [WIDTH-1:0] reg_y,
   output logic [WIDTH-1:0] resultado,
   output logic             vaium,
   output logic             zero,
   output logic             pronto,
   output logic             erro,
   output logic [2:0]       estado_dbg
);

   // Handshake: valido has no ready partner; every edge with valido=1 consumes one saida/valor pair.
   typedef enum logic [2:0] {
      OCIOSO    = 3'd0,
      APOS_X    = 3'd1,
      APOS_SOMA = 3'd2,
      APOS_Y    = 3'd3,
      APOS_DESL = 3'd4
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic             vaium_q, vaium_d, pronto_q, pronto_d, erro_q, erro_d;
   logic             legal;
   logic [WIDTH:0]   soma;
`ifdef ULA_SUB_EN
   logic [WIDTH:0]   dif;
   assign dif = {1'b0, x_q} - {1'b0, y_q};
`endif

   assign soma = {1'b0, x_q} + {1'b0, y_q};

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado_q <= OCIOSO;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         vaium_q  <= 1'b0;
         pronto_q <= 1'b0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         vaium_q  <= vaium_d;
         pronto_q <= pronto_d;
         erro_q   <= erro_d;
      end
   end

   always_comb begin
      legal    = 1'b0;
      estado_d = estado_q;
      if (valido) begin
         unique case (saida)
            4'b0000: begin
               legal    = 1'b1;
               estado_d = APOS_X;
            end
            4'b0001: if (estado_q == APOS_X) begin
               legal    = 1'b1;
               estado_d = APOS_SOMA;
            end
            4'b0010: if (estado_q == APOS_SOMA) begin
               legal    = 1'b1;
               estado_d = APOS_Y;
            end
            4'b0011: if (estado_q == APOS_Y) begin
               legal    = 1'b1;
               estado_d = APOS_DESL;
            end
            4'b0100: if (estado_q == APOS_DESL) begin
               legal    = 1'b1;
               estado_d = OCIOSO;
            end
`ifdef ULA_SUB_EN
            4'b0101: if (estado_q == APOS_SOMA || estado_q == APOS_Y || estado_q == APOS_DESL) begin
               legal = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      vaium_d  = vaium_q;
      erro_d   = erro_q;
      pronto_d = 1'b0;
      if (valido) begin
         if (!legal) begin
            erro_d = 1'b1;
         end else begin
            case (saida)
               4'b0000: begin
                  x_d     = valor;
                  y_d     = '0;
                  z_d     = '0;
                  vaium_d = 1'b0;
                  erro_d  = 1'b0;
               end
               4'b0001: begin
                  x_d     = soma[WIDTH-1:0];
                  vaium_d = soma[WIDTH];
                  y_d     = valor;
               end
               4'b0010: y_d = x_q;
               4'b0011: y_d = {1'b0, y_q[WIDTH-1:1]};
               4'b0100: begin
                  // Z takes the sum of the values held before X/Y are cleared.
                  z_d      = soma[WIDTH-1:0];
                  vaium_d  = soma[WIDTH];
                  x_d      = '0;
                  y_d      = '0;
                  pronto_d = 1'b1;
               end
`ifdef ULA_SUB_EN
               4'b0101: begin
                  x_d     = dif[WIDTH-1:0];
                  vaium_d = dif[WIDTH];
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign reg_x      = x_q;
   assign reg_y      = y_q;
   assign resultado  = z_q;
   assign vaium      = vaium_q;
   assign zero       = (z_q == '0);
   assign pronto     = pronto_q;
   assign erro       = erro_q;
   assign estado_dbg = estado_q;

endmodule

// File: doc/sequenciador_ula_xyz.md
Name: sequenciador_ula_xyz

Overview:
- Datapath stage directly downstream of the control ROM.
- Consumes the 4-bit control word (`saida`) and the immediate operand (`valor`) that the ROM produces for each count.
- Executes each word on registers X, Y and Z through an adder (ULA).
- Enforces the legal step order, flags illegal steps, and pulses `pronto` when the result lands in Z.

Parameters:
WIDTH, 4, width of `valor`, X, Y, Z and the ULA operands.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
valido  input  1  current `saida`/`valor` pair is to be executed at this edge
saida  input  4  control word from the ROM
valor  input  WIDTH  immediate operand from the ROM
reg_x  output  WIDTH  current X register
reg_y  output  WIDTH  current Y register
resultado  output  WIDTH  current Z register
vaium  output  1  carry/borrow of the last ULA write
zero  output  1  1 when `resultado` == 0
pronto  output  1  one-cycle pulse after Z is loaded
erro  output  1  sticky illegal-step flag

Behaviour:
- Reset (reset_n=0 at an edge) overrides everything at that edge:
  - X=Y=Z=0, vaium=0, pronto=0, erro=0, FSM=OCIOSO.
  - `zero` is combinational, so it reads 1 after reset.
- All registers update only at a rising edge with valido=1. With valido=0 everything holds; `pronto` still drops.
- ULA is combinational: soma = X + Y, WIDTH+1 bits. The low WIDTH bits are the value, the MSB is the carry. Results wrap modulo 2^WIDTH.
- FSM states name the last executed step: OCIOSO, APOS_X, APOS_SOMA, APOS_Y, APOS_DESL.
- Control words:
  - 0000 CARGA_X: X<=valor, Y<=0, Z<=0, vaium<=0, erro<=0. Legal in every state; goes to APOS_X. This is also the restart path mid-sequence.
  - 0001 SOMA: X<=soma[WIDTH-1:0], vaium<=soma[WIDTH], Y<=valor. Legal only in APOS_X; goes to APOS_SOMA.
  - 0010 CARGA_Y: Y<=X. Legal only in APOS_SOMA; goes to APOS_Y.
  - 0011 DESLOCA: Y<=Y>>1, logical, MSB filled with 0. Legal only in APOS_Y; goes to APOS_DESL.
  - 0100 CARGA_Z: Z<=soma[WIDTH-1:0] using the pre-clear X and Y, vaium<=soma[WIDTH], X<=0, Y<=0, pronto<=1. Legal only in APOS_DESL; goes to OCIOSO.
- Illegal step: a word out of order, or any code 0101..1111 unless enabled below.
  - No register or state change.
  - erro<=1; only CARGA_X or reset clears it.
- `pronto` timing:
  - Registered.
  - High for exactly the one cycle following the CARGA_Z edge.
  - Deasserts at the next edge regardless of valido.
- Latency: every effect is visible one cycle after the executing edge. No back-pressure; every valido=1 edge is consumed.

Optional Feature:
Macro ULA_SUB_EN.
- Defined: code 0101 SUBTRAI is added.
  - X<=(X - Y) mod 2^WIDTH; vaium<=1 when X<Y (borrow).
  - Legal in APOS_SOMA, APOS_Y and APOS_DESL; FSM state unchanged.
  - Illegal in OCIOSO and APOS_X.
- Undefined: 0101 is illegal like any other unused code.

Test Plan:
1. Reset, then with valido=1 apply 0000/2, 0001/4, 0010/0, 0011/0, 0100/0 on consecutive edges:
   - After each step: X=2,Y=0; X=2,Y=4; Y=2; Y=1; Z=3, X=Y=0.
   - pronto=1 for one cycle; vaium=0, zero=0, erro=0.
2. Overflow: sequence with valor 15, 1, 0, 0, 0 -> Y=15 then 7; Z=6 (22 mod 16), vaium=1, pronto pulses once.
3. Illegal order: 0000/5 then 0011 -> Y stays 0, erro=1, state APOS_X. Then 0001/3 -> X=5, Y=3, erro still 1. Then 0000/1 -> erro=0.
4. Hold, then mid-sequence reset:
   - valido=0 for 3 cycles mid-sequence -> X, Y, Z, vaium, FSM unchanged; pronto=0.
   - reset_n=0 together with valido=1 and 0100 -> all outputs reset, Z=0, no pronto pulse.
5. Unused code 1010 with valido=1 in APOS_SOMA -> erro=1, registers unchanged. Then 0010 -> still legal, Y<=X.
6. ULA_SUB_EN defined: 0000/2, 0001/4, then 0101 -> X=14, vaium=1, state APOS_SOMA. With the macro undefined, the same stimulus gives erro=1 and X=2.
